sdram_aref_sched: RTL and testbench



---
 rtl/sdram_aref_sched.sv | 228 ++++++++++++++++++++++
 tb/tb_sdram_aref_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_aref_sched.sv
// sdram_aref_sched
// ----------------
// Auto-refresh scheduler for the SDRAM controller. An interval counter
// produces one refresh "tick" every REF_INTERVAL cycles while init_done is
// high. Each tick adds one owed refresh (debt), saturating at MAX_DEBT. A
// tick at saturation sets the sticky overflow flag. While debt is non-zero
// and the FSM is idle, the block requests the arbiter. On grant it issues
// PRECHARGE-ALL, waits tRP, then a burst of AUTO REFRESH commands spaced
// tRFC apart until all debt is paid, and then pulses aref_done.
//
// Handshake: aref_req is a registered request, high only in IDLE with
// debt != 0. aref_en is the grant. It is sampled only in a cycle where
// aref_req is high, and a sampled grant is final: aref_req drops one edge
// later and the burst cannot be refused or stalled. aref_en at any other
// time is ignored.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   init_done   power-up init complete (level); gates the interval counter
//   aref_en     arbiter grant
//   aref_req    refresh request to the arbiter (registered)
//   urgent      debt >= URGENT_THRESH (registered, valid in any state)
//   aref_done   one-cycle pulse when the burst completes
//   sdram_cmd   {CS_n,RAS_n,CAS_n,WE_n} (registered)
//   sdram_addr  command address (registered)
//   debt        owed refresh count
//   overflow    sticky, a slot expired while debt was MAX_DEBT
//   dbg_state   current FSM state, for observation only
module sdram_aref_sched #(
  parameter int REF_INTERVAL  = 390,
  parameter int MAX_DEBT      = 8,
  parameter int URGENT_THRESH = 6,
  parameter int TRP_CYC       = 2,
  parameter int TRFC_CYC      = 4,
  parameter int ADDR_W        = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              aref_en,
  output logic              aref_req,
  output logic              urgent,
  output logic              aref_done,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [3:0]        debt,
  output logic              overflow,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRE      = 3'd1,
    S_WAIT_RP  = 3'd2,
    S_AREF     = 3'd3,
    S_WAIT_RFC = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  localparam int CNT_W    = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam int WAIT_MAX = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
  localparam int WAIT_W   = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REF_INTERVAL - 1);
  // Wait counters hold "extra cycles remaining": a wait state lasting N
  // cycles is loaded with N-1 and left when the counter reads zero.
  localparam logic [WAIT_W-1:0] RP_LOAD   = (TRP_CYC > 1) ? WAIT_W'(TRP_CYC - 2) : '0;
  localparam logic [WAIT_W-1:0] RFC_LOAD  = (TRFC_CYC > 1) ? WAIT_W'(TRFC_CYC - 2) : '0;
  localparam logic [3:0]        MAX_C     = 4'(MAX_DEBT);
  localparam logic [3:0]        URG_C     = 4'(URGENT_THRESH);
  // PRECHARGE-ALL: A10 high, all other address bits low.
  localparam logic [ADDR_W-1:0] ADDR_PALL = ADDR_W'(1024);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          debt_q, debt_d;
  logic                overflow_q, overflow_d;
  logic                aref_req_q, aref_req_d;
  logic                urgent_q, urgent_d;
  logic                aref_done_q, aref_done_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic                tick;
  logic                dec;

  // Interval counter: held at zero while init is incomplete.
  always_comb begin
    tick  = init_done && (cnt_q == CNT_LAST);
    cnt_d = cnt_q + CNT_W'(1);
    if (!init_done || tick) begin
      cnt_d = '0;
    end
  end

  // Debt bookkeeping. A tick and an AREF in the same cycle cancel, and that
  // case cannot overflow because nothing is added net.
  always_comb begin
    dec        = (state_q == S_AREF) && (debt_q != 4'd0);
    debt_d     = debt_q;
    overflow_d = overflow_q;
    if (tick && !dec) begin
      if (debt_q >= MAX_C) begin
        overflow_d = 1'b1;
      end else begin
        debt_d = debt_q + 4'd1;
      end
    end else if (!tick && dec) begin
      debt_d = debt_q - 4'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (aref_req_q && aref_en) begin
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (TRP_CYC > 1) begin
          state_d = S_WAIT_RP;
          wait_d  = RP_LOAD;
        end else begin
          state_d = S_AREF;
        end
      end
      S_WAIT_RP: begin
        if (wait_q == '0) begin
          state_d = S_AREF;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_AREF: begin
        if (TRFC_CYC > 1) begin
          state_d = S_WAIT_RFC;
          wait_d  = RFC_LOAD;
        end else begin
          // No spacing state: decide on the post-decrement debt directly.
          state_d = (debt_d != 4'd0) ? S_AREF : S_DONE;
        end
      end
      S_WAIT_RFC: begin
        if (wait_q == '0) begin
          // debt_q already includes the last decrement and any ticks that
          // arrived during the burst.
          state_d = (debt_q != 4'd0) ? S_AREF : S_DONE;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs are derived from the current state, so each command
  // appears one edge after the FSM enters the state that issues it.
  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = '0;
    case (state_q)
      S_PRE: begin
        cmd_d  = CMD_PRE;
        addr_d = ADDR_PALL;
      end
      S_AREF: begin
        cmd_d = CMD_AREF;
      end
      default: begin
        cmd_d = CMD_NOP;
      end
    endcase
    aref_done_d = (state_q == S_DONE);
    aref_req_d  = (state_q == S_IDLE) && (debt_q != 4'd0);
    urgent_d    = (debt_d >= URG_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      cnt_q       <= '0;
      debt_q      <= 4'd0;
      overflow_q  <= 1'b0;
      aref_req_q  <= 1'b0;
      urgent_q    <= 1'b0;
      aref_done_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      cnt_q       <= cnt_d;
      debt_q      <= debt_d;
      overflow_q  <= overflow_d;
      aref_req_q  <= aref_req_d;
      urgent_q    <= urgent_d;
      aref_done_q <= aref_done_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
    end
  end

  assign aref_req   = aref_req_q;
  assign urgent     = urgent_q;
  assign aref_done  = aref_done_q;
  assign sdram_cmd  = cmd_q;
  assign sdram_addr = addr_q;
  assign debt       = debt_q;
  assign overflow   = overflow_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sdram_aref_sched.sv
// Bench for sdram_aref_sched with REF_INTERVAL=20 and default timing.
// A vector table covers reset and a single refresh cycle by cycle, then
// hand-written sequences cover init gating, postponed bursts, saturation,
// a tick coinciding with AREF, and reset in the middle of a burst.
module tb_sdram_aref_sched;

  localparam int RI    = 20;
  localparam int TRP   = 2;
  localparam int TRFC  = 4;
  localparam int URG   = 6;
  localparam int AW    = 13;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [AW-1:0] A10 = 13'h0400;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst;
  logic          init_done;
  logic          aref_en;
  logic          aref_req;
  logic          urgent;
  logic          aref_done;
  logic [3:0]    sdram_cmd;
  logic [AW-1:0] sdram_addr;
  logic [3:0]    debt;
  logic          overflow;
  logic [2:0]    dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sdram_aref_sched #(
    .REF_INTERVAL (RI),
    .MAX_DEBT     (8),
    .URGENT_THRESH(URG),
    .TRP_CYC      (TRP),
    .TRFC_CYC     (TRFC),
    .ADDR_W       (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .init_done (init_done),
    .aref_en   (aref_en),
    .aref_req  (aref_req),
    .urgent    (urgent),
    .aref_done (aref_done),
    .sdram_cmd (sdram_cmd),
    .sdram_addr(sdram_addr),
    .debt      (debt),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int vec_cnt = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Drive inputs, advance one rising edge, then sample 1 time unit later.
  task automatic step(input logic r, input logic i, input logic e);
    rst       = r;
    init_done = i;
    aref_en   = e;
    @(posedge clk);
    #1;
  endtask

  // Grant a pending request and follow the whole burst. d0 is the debt at
  // grant, n the number of AREFs expected, bump the index of the AREF that
  // coincides with a tick (-1 for none).
  task automatic run_burst(input string tag, input int d0, input int n, input int bump,
                           input logic init, input logic exp_ovf);
    int d;
    int done_o;
    int k;
    logic [3:0]    ec;
    logic [AW-1:0] ea;
    d      = d0;
    done_o = 1 + TRP + TRFC * n;
    step(1'b0, init, 1'b1);
    chk($sformatf("%s.req_at_grant", tag), 32'(aref_req), 32'd1);
    chk($sformatf("%s.cmd_at_grant", tag), 32'(sdram_cmd), 32'(NOP));
    for (int o = 1; o <= done_o + 1; o++) begin
      step(1'b0, init, 1'b1);
      ec = NOP;
      ea = '0;
      if (o == 1) begin
        ec = PRE;
        ea = A10;
      end else if (o >= 1 + TRP && ((o - 1 - TRP) % TRFC) == 0 && ((o - 1 - TRP) / TRFC) < n) begin
        ec = AREF;
        k  = (o - 1 - TRP) / TRFC;
        d  = d - 1 + ((k == bump) ? 1 : 0);
      end
      chk($sformatf("%s.o%0d.cmd", tag, o), 32'(sdram_cmd), 32'(ec));
      chk($sformatf("%s.o%0d.addr", tag, o), 32'(sdram_addr), 32'(ea));
      chk($sformatf("%s.o%0d.done", tag, o), 32'(aref_done), (o == done_o) ? 32'd1 : 32'd0);
      chk($sformatf("%s.o%0d.req", tag, o), 32'(aref_req), 32'd0);
      chk($sformatf("%s.o%0d.debt", tag, o), 32'(debt), 32'(d));
      chk($sformatf("%s.o%0d.urgent", tag, o), 32'(urgent), (d >= URG) ? 32'd1 : 32'd0);
      chk($sformatf("%s.o%0d.ovf", tag, o), 32'(overflow), 32'(exp_ovf));
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic          init;
    logic          en;
    logic          req;
    logic          urg;
    logic          done;
    logic [3:0]    cmd;
    logic [AW-1:0] addr;
    logic [3:0]    debt;
    logic          ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic i, input logic e,
                     input logic q, input logic u, input logic dn,
                     input logic [3:0] c, input logic [AW-1:0] a,
                     input logic [3:0] db, input logic o);
    vec_t v;
    v.rst = r; v.init = i; v.en = e;
    v.req = q; v.urg = u; v.done = dn;
    v.cmd = c; v.addr = a; v.debt = db; v.ovf = o;
    vecs.push_back(v);
  endtask

  initial begin
    rst       = 1'b1;
    init_done = 1'b0;
    aref_en   = 1'b0;

    // Reset for 5 cycles, then single refresh with aref_en held high.
    // Edge numbers below count from the first edge with init_done=1.
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, NOP, '0, 4'd0, 0);
    for (int i = 1; i <= 19; i++) add(0, 1, 1, 0, 0, 0, NOP, '0, 4'd0, 0);
    add(0, 1, 1, 0, 0, 0, NOP,  '0,  4'd1, 0); // 20: tick, debt=1
    add(0, 1, 1, 1, 0, 0, NOP,  '0,  4'd1, 0); // 21: request
    add(0, 1, 1, 1, 0, 0, NOP,  '0,  4'd1, 0); // 22: grant sampled
    add(0, 1, 1, 0, 0, 0, PRE,  A10, 4'd1, 0); // 23: PRECHARGE-ALL
    add(0, 1, 1, 0, 0, 0, NOP,  '0,  4'd1, 0); // 24: tRP
    add(0, 1, 1, 0, 0, 0, AREF, '0,  4'd0, 0); // 25: AREF
    for (int i = 26; i <= 28; i++) add(0, 1, 1, 0, 0, 0, NOP, '0, 4'd0, 0);
    add(0, 1, 1, 0, 0, 1, NOP,  '0,  4'd0, 0); // 29: done pulse
    add(0, 1, 1, 0, 0, 0, NOP,  '0,  4'd0, 0); // 30: idle

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].init, vecs[i].en);
      chk($sformatf("v%0d.req", i),  32'(aref_req),   32'(vecs[i].req));
      chk($sformatf("v%0d.urg", i),  32'(urgent),     32'(vecs[i].urg));
      chk($sformatf("v%0d.done", i), 32'(aref_done),  32'(vecs[i].done));
      chk($sformatf("v%0d.cmd", i),  32'(sdram_cmd),  32'(vecs[i].cmd));
      chk($sformatf("v%0d.addr", i), 32'(sdram_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d.debt", i), 32'(debt),       32'(vecs[i].debt));
      chk($sformatf("v%0d.ovf", i),  32'(overflow),   32'(vecs[i].ovf));
    end

    // ---- init_done low for 1000 cycles: nothing accrues ----
    step(1, 0, 0);
    step(1, 0, 0);
    chk("rst.state", 32'(dbg_state), 32'd0);
    for (int i = 0; i < 1000; i++) begin
      step(0, 0, 1);
      chk("noinit.debt", 32'(debt), 32'd0);
      chk("noinit.req", 32'(aref_req), 32'd0);
    end

    // ---- postponed burst: 6 owed refreshes ----
    step(1, 0, 0);
    for (int i = 1; i <= 100; i++) step(0, 1, 0);
    chk("post.debt5", 32'(debt), 32'd5);
    chk("post.urg5", 32'(urgent), 32'd0);
    chk("post.req5", 32'(aref_req), 32'd1);
    for (int i = 1; i <= 20; i++) step(0, 1, 0);
    chk("post.debt6", 32'(debt), 32'd6);
    chk("post.urg6", 32'(urgent), 32'd1);
    // init_done dropped for the burst so no tick lands inside it.
    run_burst("post", 6, 6, -1, 1'b0, 1'b0);

    // ---- saturation: 10 ticks without grant ----
    step(1, 0, 0);
    for (int i = 1; i <= 160; i++) step(0, 1, 0);
    chk("sat.debt8", 32'(debt), 32'd8);
    chk("sat.ovf_before", 32'(overflow), 32'd0);
    for (int i = 1; i <= 20; i++) step(0, 1, 0);
    chk("sat.ovf_9th", 32'(overflow), 32'd1);
    chk("sat.debt_9th", 32'(debt), 32'd8);
    for (int i = 1; i <= 20; i++) step(0, 1, 0);
    chk("sat.debt_10th", 32'(debt), 32'd8);
    chk("sat.urg", 32'(urgent), 32'd1);
    run_burst("sat", 8, 8, -1, 1'b0, 1'b1);
    step(0, 0, 0);
    chk("sat.ovf_sticky", 32'(overflow), 32'd1);
    step(1, 0, 0);
    chk("sat.ovf_rst", 32'(overflow), 32'd0);

    // ---- tick aligned with the AREF edge (edge 40 = grant 37 + 3) ----
    step(1, 0, 0);
    for (int i = 1; i <= 36; i++) step(0, 1, 0);
    chk("tick.req", 32'(aref_req), 32'd1);
    chk("tick.debt", 32'(debt), 32'd1);
    run_burst("tick", 1, 2, 0, 1'b1, 1'b0);

    // ---- reset in WAIT_RFC ----
    step(1, 0, 0);
    for (int i = 1; i <= 40; i++) step(0, 1, 0);
    chk("mid.debt2", 32'(debt), 32'd2);
    step(0, 1, 1);                              // 41: grant
    step(0, 1, 1);                              // 42
    chk("mid.pre", 32'(sdram_cmd), 32'(PRE));
    step(0, 1, 1);                              // 43
    step(0, 1, 1);                              // 44
    chk("mid.aref", 32'(sdram_cmd), 32'(AREF));
    chk("mid.debt1", 32'(debt), 32'd1);
    step(1, 1, 1);                              // 45: reset in WAIT_RFC
    chk("mid.rst_cmd", 32'(sdram_cmd), 32'(NOP));
    chk("mid.rst_debt", 32'(debt), 32'd0);
    chk("mid.rst_req", 32'(aref_req), 32'd0);
    chk("mid.rst_state", 32'(dbg_state), 32'd0);
    for (int i = 1; i <= 19; i++) begin
      step(0, 1, 1);
      chk("mid.quiet_cmd", 32'(sdram_cmd), 32'(NOP));
      chk("mid.quiet_debt", 32'(debt), 32'd0);
      chk("mid.quiet_req", 32'(aref_req), 32'd0);
    end
    step(0, 1, 1);
    chk("mid.tick_debt", 32'(debt), 32'd1);
    chk("mid.tick_cmd", 32'(sdram_cmd), 32'(NOP));
    step(0, 1, 1);
    chk("mid.req", 32'(aref_req), 32'd1);
    step(0, 1, 1);
    chk("mid.grant_cmd", 32'(sdram_cmd), 32'(NOP));
    step(0, 1, 1);
    chk("mid.pre2", 32'(sdram_cmd), 32'(PRE));
    chk("mid.pre2_addr", 32'(sdram_addr), 32'(A10));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
